// File: rtl/tx_fifo_arbiter.sv
// Round-robin egress arbiter between the per-port TX FIFOs and the SDRAM
// command FSM; also owns the refresh timer and the ref_req/ref_ack handshake.
//
// Ports:
//   sdram_clk_0, wb_rst        clock, async active-high reset
//   fifo_empty_i, fifo_dat_i   per-port FIFO empty flags and 36-bit head words
//   fifo_rd_o                  one-hot pop strobe to the granted FIFO
//   fifo_re, done              pop request and burst-complete from the FSM
//   ref_req, ref_ack           refresh handshake with the FSM
//   tx_fifo_dat_o/_empty       head word / empty flag of the granted port
//   tx_fifo_b_sel_i_cur        granted port index, zero-extended to 4 bits
module tx_fifo_arbiter #(
  parameter int nr_of_ports   = 4,
  parameter int ref_period    = 1560,
  parameter int ref_cnt_width = 11
) (
  input  logic                     sdram_clk_0,
  input  logic                     wb_rst,
  input  logic [nr_of_ports-1:0]   fifo_empty_i,
  input  logic [36*nr_of_ports-1:0] fifo_dat_i,
  output logic [nr_of_ports-1:0]   fifo_rd_o,
  input  logic                     fifo_re,
  input  logic                     done,
  input  logic                     ref_ack,
  output logic                     ref_req,
  output logic [35:0]              tx_fifo_dat_o,
  output logic                     tx_fifo_empty,
  output logic [3:0]               tx_fifo_b_sel_i_cur
);

  localparam int SW = (nr_of_ports > 1) ? $clog2(nr_of_ports) : 1;
  localparam logic [ref_cnt_width-1:0] RELOAD =
    ref_cnt_width'(ref_period - 1);
  localparam logic [SW-1:0] LAST_RST = SW'(nr_of_ports - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK    = 2'd1,
    REFRESH = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [SW-1:0]            sel_q, sel_d;
  logic [SW-1:0]            last_q, last_d;
  logic [ref_cnt_width-1:0] ref_cnt_q, ref_cnt_d;
  logic                     ref_pend_q, ref_pend_d;

  logic                     expire;
  logic                     rr_hit;
  logic [SW-1:0]            rr_pick;

  // State register
  always_ff @(posedge sdram_clk_0 or posedge wb_rst) begin
    if (wb_rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      last_q     <= LAST_RST;
      ref_cnt_q  <= RELOAD;
      ref_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
    end
  end

  // Refresh timer; a new expiry outranks a same-cycle ack so it is
  // never lost, otherwise the pending flag is sticky until acked.
  always_comb begin
    expire     = (ref_cnt_q == '0);
    ref_cnt_d  = expire ? RELOAD : ref_cnt_q - 1'b1;
    ref_pend_d = ref_pend_q;
    if (state_q == REFRESH && ref_ack)
      ref_pend_d = 1'b0;
    if (expire)
      ref_pend_d = 1'b1;
  end

  // Search downward so the closest port after last wins.
  always_comb begin
    logic [SW-1:0] k;
    rr_hit  = 1'b0;
    rr_pick = '0;
    k       = '0;
    for (int i = nr_of_ports; i >= 1; i--) begin
      k = SW'((int'(last_q) + i) % nr_of_ports);
      if (!fifo_empty_i[k]) begin
        rr_hit  = 1'b1;
        rr_pick = k;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (ref_pend_q) begin
          state_d = REFRESH;
        end else if (rr_hit) begin
          sel_d   = rr_pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (done) begin
          last_d  = sel_q;
          state_d = IDLE;
        end
      end
      REFRESH: begin
        if (ref_ack)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ref_req             = (state_q == REFRESH);
    tx_fifo_empty       = 1'b1;
    fifo_rd_o           = '0;
    tx_fifo_dat_o       = fifo_dat_i[36*sel_q +: 36];
    tx_fifo_b_sel_i_cur = 4'(sel_q);
    if (state_q == LOCK) begin
      tx_fifo_empty = fifo_empty_i[sel_q];
      if (fifo_re && !fifo_empty_i[sel_q])
        fifo_rd_o[sel_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Directed bench for tx_fifo_arbiter: a default instance for arbitration
// and a short-period instance for the refresh handshake.
module tb_tx_fifo_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   empty;
  logic [143:0] dat;
  logic         re;
  logic         done;
  logic         ack_a;
  logic         ack_b;

  logic [3:0]   rd_a, rd_b;
  logic         req_a, req_b;
  logic [35:0]  dat_a, dat_b;
  logic         emp_a, emp_b;
  logic [3:0]   sel_a, sel_b;

  int checks;
  int errors;

  tx_fifo_arbiter dut_a (
    .sdram_clk_0         (clk),
    .wb_rst              (rst),
    .fifo_empty_i        (empty),
    .fifo_dat_i          (dat),
    .fifo_rd_o           (rd_a),
    .fifo_re             (re),
    .done                (done),
    .ref_ack             (ack_a),
    .ref_req             (req_a),
    .tx_fifo_dat_o       (dat_a),
    .tx_fifo_empty       (emp_a),
    .tx_fifo_b_sel_i_cur (sel_a)
  );

  tx_fifo_arbiter #(
    .nr_of_ports   (4),
    .ref_period    (16),
    .ref_cnt_width (5)
  ) dut_b (
    .sdram_clk_0         (clk),
    .wb_rst              (rst),
    .fifo_empty_i        (empty),
    .fifo_dat_i          (dat),
    .fifo_rd_o           (rd_b),
    .fifo_re             (re),
    .done                (done),
    .ref_ack             (ack_b),
    .ref_req             (req_b),
    .tx_fifo_dat_o       (dat_b),
    .tx_fifo_empty       (emp_b),
    .tx_fifo_b_sel_i_cur (sel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] word(input int p);
    return {4'(p + 5), 32'hC0DE_0000 + 32'(p)};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_lock_a(input string tag);
    int n;
    n = 0;
    while (emp_a && n < 8) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < 8), 64'd1);
  endtask

  initial begin
    int n;
    int rises;
    int first;
    logic prev;
    logic [3:0] exp_p;

    checks = 0;
    errors = 0;
    for (int p = 0; p < 4; p++)
      dat[36*p +: 36] = word(p);
    empty = 4'hF;
    re    = 1'b0;
    done  = 1'b0;
    ack_a = 1'b0;
    ack_b = 1'b0;

    // Reset values and 200 idle cycles with fifo_re/done noise
    do_reset();
    settle();
    chk("rst_empty", 64'(emp_a), 64'd1);
    chk("rst_rd", 64'(rd_a), 64'd0);
    chk("rst_req", 64'(req_a), 64'd0);
    chk("rst_sel", 64'(sel_a), 64'd0);
    chk("rst_dat", 64'(dat_a), 64'(word(0)));
    n = 0;
    for (int i = 0; i < 200; i++) begin
      re   = i[0];
      done = i[1];
      tick();
      if (rd_a != 4'd0 || !emp_a || req_a) n++;
    end
    re   = 1'b0;
    done = 1'b0;
    chk("idle_quiet", 64'(n), 64'd0);

    // Round robin between ports 0 and 2
    do_reset();
    empty = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      exp_p = (g % 2 == 1) ? 4'd2 : 4'd0;
      wait_lock_a("rr_lock");
      chk("rr_sel", 64'(sel_a), 64'(exp_p));
      chk("rr_dat", 64'(dat_a), 64'(word(int'(exp_p))));
      repeat (4) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
    end

    // Pops on port 1 and empty-in-lock
    do_reset();
    empty = 4'b1101;
    wait_lock_a("pop_lock");
    chk("pop_sel", 64'(sel_a), 64'd1);
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("pop_rd", 64'(rd_a), 64'b0010);
      tick();
    end
    re = 1'b0;
    settle();
    chk("pop_rd_off", 64'(rd_a), 64'd0);
    empty = 4'b1111;
    re    = 1'b1;
    settle();
    chk("pop_empty_rd", 64'(rd_a), 64'd0);
    chk("pop_empty_flag", 64'(emp_a), 64'd1);
    repeat (3) tick();
    empty = 4'b0000;
    settle();
    chk("pop_hold_sel", 64'(sel_a), 64'd1);
    chk("pop_hold_emp", 64'(emp_a), 64'd0);
    chk("pop_hold_rd", 64'(rd_a), 64'b0010);
    re   = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;

    // Refresh held off by a burst, then withheld ack
    rst   = 1'b1;
    empty = 4'b1110;
    do_reset();
    tick();
    chk("ref_lock", 64'(sel_b), 64'd0);
    empty = 4'b0110;
    repeat (19) tick();
    chk("ref_no_int", 64'(req_b), 64'd0);
    chk("ref_no_int_emp", 64'(emp_b), 64'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("ref_idle", 64'(req_b), 64'd0);
    tick();
    chk("ref_req_on", 64'(req_b), 64'd1);
    chk("ref_no_grant", 64'(emp_b), 64'd1);
    n = 0;
    repeat (43) begin
      tick();
      if (req_b) n++;
    end
    chk("ref_held", 64'(n), 64'd43);
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;
    chk("ref_req_off", 64'(req_b), 64'd0);
    tick();
    chk("ref_grant3", 64'(sel_b), 64'd3);
    chk("ref_grant3_emp", 64'(emp_b), 64'd0);
    done = 1'b1;
    tick();
    done  = 1'b0;
    empty = 4'hF;
    rises = 0;
    first = -1;
    prev  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_b && !prev) begin
        rises++;
        if (first < 0) first = i;
      end
      prev  = req_b;
      ack_b = req_b;
    end
    ack_b = 1'b0;
    chk("ref_one_req", 64'(rises), 64'd1);
    chk("ref_req_time", 64'(first), 64'd12);

    // done and expiry in the same cycle
    rst   = 1'b1;
    empty = 4'b1110;
    do_reset();
    tick();
    repeat (14) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("coinc_req", 64'(req_b), 64'd1);
    chk("coinc_emp", 64'(emp_b), 64'd1);
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;

    // Async reset mid-burst
    do_reset();
    empty = 4'b1011;
    wait_lock_a("rst_lock");
    chk("rst_lock_sel", 64'(sel_a), 64'd2);
    re = 1'b1;
    settle();
    chk("rst_lock_rd", 64'(rd_a), 64'b0100);
    rst = 1'b1;
    settle();
    chk("rst_async_rd", 64'(rd_a), 64'd0);
    chk("rst_async_sel", 64'(sel_a), 64'd0);
    chk("rst_async_emp", 64'(emp_a), 64'd1);
    re    = 1'b0;
    empty = 4'b1001;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("rst_regrant", 64'(sel_a), 64'd1);
    chk("rst_regrant_emp", 64'(emp_a), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
